// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : CPU-side read/status bundle of the UART receiver FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    logic [7:0] data;
    logic       ready;
    logic       read_strobe;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;

    modport slave (
        output data, ready, frame_err, overrun,
        input  read_strobe, err_clear
    );

    modport master (
        input  data, ready, frame_err, overrun,
        output read_strobe, err_clear
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver, 16x oversampled, 3-sample vote, receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         baudclk16,
    input  wire logic         rxd,
    uart_rx_fifo_if.slave     bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [2:0]            state, state_next;
    logic                  rxd_meta, rxd_s;
    logic [3:0]            tick_cnt;
    logic [2:0]            bit_idx;
    logic                  samp7, samp8;
    logic [7:0]            shreg;
    logic                  strobe_q;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  frame_err, overrun;

    logic majority, empty, full, pop, push;
    logic push_req, frame_set, overrun_set;

    // The third vote is the live sample on the tick-9 cycle itself.
    assign majority = (samp7 & samp8) | (samp7 & rxd_s) | (samp8 & rxd_s);
    assign empty    = (count == '0);
    assign full     = (count == DEPTH[DEPTH_LOG2:0]);
    assign pop      = bus.read_strobe & ~strobe_q & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rxd_meta  <= 1'b1;
            rxd_s     <= 1'b1;
            tick_cnt  <= 4'd0;
            bit_idx   <= 3'd0;
            samp7     <= 1'b1;
            samp8     <= 1'b1;
            shreg     <= 8'h00;
            strobe_q  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state    <= state_next;
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            strobe_q <= bus.read_strobe;

            if (baudclk16) begin
                if (state == S_IDLE || state == S_BREAK)
                    tick_cnt <= 4'd0;
                else
                    tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'd7) samp7 <= rxd_s;
                if (tick_cnt == 4'd8) samp8 <= rxd_s;
                if (state == S_START)
                    bit_idx <= 3'd0;
                else if (state == S_DATA && tick_cnt == 4'd15)
                    bit_idx <= bit_idx + 3'd1;
                if (state == S_DATA && tick_cnt == 4'd9)
                    shreg <= {majority, shreg[7:1]};
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            // Set takes priority over a simultaneous clear.
            if (frame_set)          frame_err <= 1'b1;
            else if (bus.err_clear) frame_err <= 1'b0;
            if (overrun_set)        overrun   <= 1'b1;
            else if (bus.err_clear) overrun   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (baudclk16 && !rxd_s) state_next = S_START;
            S_START: if (baudclk16) begin
                         if (tick_cnt == 4'd9 && majority) state_next = S_IDLE;
                         else if (tick_cnt == 4'd15)       state_next = S_DATA;
                     end
            S_DATA:  if (baudclk16 && tick_cnt == 4'd15 && bit_idx == 3'd7)
                         state_next = S_STOP;
            // Leaving at tick 9 gives half a bit of slack for a fast sender.
            S_STOP:  if (baudclk16 && tick_cnt == 4'd9)
                         state_next = majority ? S_IDLE : S_BREAK;
            S_BREAK: if (baudclk16 && rxd_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        push_req    = (state == S_STOP) && baudclk16 && (tick_cnt == 4'd9) && majority;
        frame_set   = (state == S_STOP) && baudclk16 && (tick_cnt == 4'd9) && !majority;
        push        = push_req && (!full || pop);
        overrun_set = push_req && full && !pop;
    end

    assign bus.data      = empty ? 8'h00 : mem[rd_ptr];
    assign bus.ready     = ~empty;
    assign bus.frame_err = frame_err;
    assign bus.overrun   = overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed scoreboard bench for uart_rx_fifo (scaled baud tick).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int BIT_CYC = 64;   // 16 ticks x 4 clocks per tick

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic baudclk16 = 1'b0;
    logic rxd = 1'b1;
    logic [1:0] div = 2'd0;
    int checks = 0;
    int errors = 0;
    int lat;
    logic [7:0] exp_q [$];

    uart_rx_fifo_if bus ();

    uart_rx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .baudclk16 (baudclk16),
        .rxd       (rxd),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = div + 2'd1;
        baudclk16 = (div == 2'd0);
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rxd is left at the stop-bit level so a bad stop can be held low.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rxd = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(BIT_CYC);
        end
        rxd = stop_val;
        idle(BIT_CYC);
    endtask

    task automatic read_one(input string tag);
        logic [7:0] e;
        e = 8'h00;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check1({tag, "_ready"}, bus.ready, 1'b1);
        check8({tag, "_data"}, bus.data, e);
        bus.read_strobe = 1'b1;
        idle(1);
        bus.read_strobe = 1'b0;
        idle(1);
    endtask

    task automatic pulse_clear();
        bus.err_clear = 1'b1;
        idle(1);
        bus.err_clear = 1'b0;
        idle(1);
    endtask

    initial begin
        bus.read_strobe = 1'b0;
        bus.err_clear   = 1'b0;
        idle(5);
        reset = 1'b0;
        idle(2);
        check1("rst_ready", bus.ready, 1'b0);
        check8("rst_data", bus.data, 8'h00);
        check1("rst_frame", bus.frame_err, 1'b0);
        check1("rst_overrun", bus.overrun, 1'b0);

        // 1: single byte with latency measurement
        exp_q.push_back(8'h55);
        lat = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (!bus.ready && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check1("t1_latency", (lat >= 605 && lat <= 625), 1'b1);
        idle(8);
        read_one("t1");
        check1("t1_empty", bus.ready, 1'b0);
        check8("t1_data0", bus.data, 8'h00);
        bus.read_strobe = 1'b1;
        idle(2);
        bus.read_strobe = 1'b0;
        idle(1);
        check1("t1_pop_empty", bus.ready, 1'b0);

        // 2: glitch shorter than half a bit
        rxd = 1'b0;
        idle(16);
        rxd = 1'b1;
        idle(4 * BIT_CYC);
        check1("t2_ready", bus.ready, 1'b0);
        check1("t2_frame", bus.frame_err, 1'b0);
        check1("t2_overrun", bus.overrun, 1'b0);

        // 3: overflow the 4-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
            idle(16);
        end
        check1("t3_overrun", bus.overrun, 1'b1);
        check1("t3_frame", bus.frame_err, 1'b0);
        for (int i = 0; i < 4; i++) read_one("t3_pop");
        check1("t3_empty", bus.ready, 1'b0);
        pulse_clear();
        check1("t3_ovr_clr", bus.overrun, 1'b0);

        // 4: framing error, break, recovery
        send_byte(8'hA3, 1'b0);
        idle(3 * BIT_CYC);
        check1("t4_frame", bus.frame_err, 1'b1);
        check1("t4_ready", bus.ready, 1'b0);
        rxd = 1'b1;
        idle(BIT_CYC);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        idle(16);
        check1("t4_frame_sticky", bus.frame_err, 1'b1);
        read_one("t4");
        pulse_clear();
        check1("t4_frame_clr", bus.frame_err, 1'b0);

        // 5: long strobe pops exactly once
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        idle(16);
        exp_q.push_back(8'h22);
        send_byte(8'h22, 1'b1);
        idle(16);
        bus.read_strobe = 1'b1;
        idle(2);
        bus.read_strobe = 1'b0;
        idle(1);
        void'(exp_q.pop_front());
        check1("t5_ready", bus.ready, 1'b1);
        read_one("t5");
        check1("t5_empty", bus.ready, 1'b0);

        // 6: reset in the middle of a frame
        fork
            send_byte(8'hF0, 1'b1);
            begin
                idle(5 * BIT_CYC + BIT_CYC / 2);
                reset = 1'b1;
                idle(2);
                reset = 1'b0;
            end
        join
        idle(16);
        check1("t6_ready_after_rst", bus.ready, 1'b0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        idle(16);
        check1("t6_frame", bus.frame_err, 1'b0);
        check1("t6_overrun", bus.overrun, 1'b0);
        read_one("t6");
        check1("t6_empty", bus.ready, 1'b0);
        check8("t6_scoreboard_left", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
